// File: rtl/alarm_ctrl_pkg.sv
// Shared types and helpers for the alarm controller: FSM state, default
// timing constants and packed-BCD utilities.
package alarm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alarm_state_t;

  localparam int DEFAULT_CLK_FREQ   = 12_000_000;
  localparam int DEFAULT_TONE_HZ    = 2000;
  localparam int DEFAULT_RING_SECS  = 60;
  localparam int DEFAULT_SNOOZE_MIN = 5;

  // True when both digits are decimal and the value does not exceed max_bcd.
  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max_bcd);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max_bcd);
  endfunction

  // Adds add_min minutes to h:m (packed BCD), wrapping 59->00 with hour carry
  // and 23->00. Always returns a legal time, even from malformed input.
  function automatic logic [15:0] bcd_add_hm(input logic [7:0] h, input logic [7:0] m,
                                             input int add_min);
    int hb;
    int mb;
    hb = int'(h[7:4]) * 10 + int'(h[3:0]);
    mb = int'(m[7:4]) * 10 + int'(m[3:0]) + add_min;
    if (mb >= 60) begin
      mb = mb - 60;
      hb = hb + 1;
    end
    if (hb >= 24) hb = hb - 24;
    if (mb > 59) mb = 0;
    if (hb > 23) hb = 0;
    return {4'(hb / 10), 4'(hb % 10), 4'(mb / 10), 4'(mb % 10)};
  endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Bundle of time/alarm inputs, user keys and status outputs of alarm_ctrl.
interface alarm_ctrl_if;
  import alarm_ctrl_pkg::*;

  logic [7:0]   hour_bcd;
  logic [7:0]   minute_bcd;
  logic [7:0]   second_bcd;
  logic [7:0]   alarm_hour;
  logic [7:0]   alarm_minute;
  logic         alarm_en;
  // Keys are single-cycle pulses with no handshake: sampled on every rising
  // edge, a pulse is consumed in the cycle it is high and never held off.
  logic         stop_key;
  logic         snooze_key;
  logic         buzzer;
  logic         ringing;
  logic         snoozed;
  alarm_state_t state;

  modport master (
    output hour_bcd, minute_bcd, second_bcd, alarm_hour, alarm_minute,
           alarm_en, stop_key, snooze_key,
    input  buzzer, ringing, snoozed, state
  );

  modport slave (
    input  hour_bcd, minute_bcd, second_bcd, alarm_hour, alarm_minute,
           alarm_en, stop_key, snooze_key,
    output buzzer, ringing, snoozed, state
  );
endinterface

// File: rtl/alarm_tone_gen.sv
// Buzzer waveform: a 1 Hz on/off pattern gating a TONE_HZ square wave.
// 'start' restarts the pattern in its "on" half; 'en' low forces silence.
module alarm_tone_gen import alarm_ctrl_pkg::*; #(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int TONE_HZ  = DEFAULT_TONE_HZ
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic start,
  output logic buzzer
);

  localparam int HALF_RAW = CLK_FREQ / 2;
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int TDIV_RAW = CLK_FREQ / (2 * TONE_HZ);
  localparam int TDIV     = (TDIV_RAW < 1) ? 1 : TDIV_RAW;
  localparam int PW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int TW       = (TDIV > 1) ? $clog2(TDIV) : 1;

  localparam logic [PW-1:0] HALF_LAST = PW'(HALF - 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TDIV - 1);

  logic [PW-1:0] phase_cnt;
  logic [TW-1:0] tone_cnt;
  logic          phase_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_cnt <= '0;
      tone_cnt  <= '0;
      phase_on  <= 1'b0;
      buzzer    <= 1'b0;
    end else if (!en) begin
      phase_cnt <= '0;
      tone_cnt  <= '0;
      phase_on  <= 1'b0;
      buzzer    <= 1'b0;
    end else if (start) begin
      phase_cnt <= '0;
      tone_cnt  <= '0;
      phase_on  <= 1'b1;
      buzzer    <= 1'b1;
    end else if (phase_cnt == HALF_LAST) begin
      // Half-second boundary: flip the pattern; a new "on" half starts high.
      phase_cnt <= '0;
      tone_cnt  <= '0;
      phase_on  <= ~phase_on;
      buzzer    <= ~phase_on;
    end else begin
      phase_cnt <= phase_cnt + 1'b1;
      if (phase_on) begin
        if (tone_cnt == TONE_LAST) begin
          tone_cnt <= '0;
          buzzer   <= ~buzzer;
        end else begin
          tone_cnt <= tone_cnt + 1'b1;
        end
      end else begin
        buzzer <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: IDLE/RING/SNOOZE FSM driven by BCD time-of-day.
// Define ALARM_SNOOZE_EN to build the SNOOZE state; otherwise snooze_key stops.
module alarm_ctrl import alarm_ctrl_pkg::*; #(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int TONE_HZ    = DEFAULT_TONE_HZ,
  parameter int RING_SECS  = DEFAULT_RING_SECS,
  parameter int SNOOZE_MIN = DEFAULT_SNOOZE_MIN
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  alarm_ctrl_if.slave  bus
);

  if (RING_SECS < 1 || RING_SECS > 255) begin : g_bad_ring_secs
    $error("alarm_ctrl: RING_SECS must be in 1..255");
  end
  if (SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_snooze_min
    $error("alarm_ctrl: SNOOZE_MIN must be in 1..59");
  end

  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

  alarm_state_t state;
  logic [7:0]   ring_cnt;
  logic [7:0]   sec_q;
  logic         match_a;
  logic         match_a_q;
  logic         trig_a;
  logic         time_valid;
  logic         tick;
  logic         stop_req;
  logic         snooze_req;
  logic         enter_ring;
  logic         leave_ring;
  logic         tone_en;
  logic         buzzer;

`ifdef ALARM_SNOOZE_EN
  logic [7:0]   snz_h;
  logic [7:0]   snz_m;
  logic         match_s;
  logic         match_s_q;
  logic         trig_s;
`endif

  // Alarm and snooze targets keep separate edge detectors, so leaving
  // SNOOZE inside the alarm's own matching second cannot fire it twice.
  always_comb begin
    time_valid = bcd_valid(bus.hour_bcd, 8'h23) && bcd_valid(bus.minute_bcd, 8'h59)
                 && (bus.second_bcd == 8'h00);
    match_a    = bus.alarm_en && time_valid && (bus.hour_bcd == bus.alarm_hour)
                 && (bus.minute_bcd == bus.alarm_minute);
    trig_a     = match_a && !match_a_q;
    tick       = (bus.second_bcd != sec_q);
`ifdef ALARM_SNOOZE_EN
    match_s    = bus.alarm_en && time_valid && (bus.hour_bcd == snz_h)
                 && (bus.minute_bcd == snz_m);
    trig_s     = match_s && !match_s_q;
    stop_req   = bus.stop_key;
    snooze_req = bus.snooze_key && !bus.stop_key;
    enter_ring = bus.alarm_en && (((state == ST_IDLE) && trig_a)
                 || ((state == ST_SNOOZE) && trig_s && !bus.stop_key));
`else
    stop_req   = bus.stop_key || bus.snooze_key;
    snooze_req = 1'b0;
    enter_ring = bus.alarm_en && (state == ST_IDLE) && trig_a;
`endif
    leave_ring = (state == ST_RING) && (!bus.alarm_en || stop_req || snooze_req
                 || (tick && (ring_cnt == RING_LAST)));
    // Tone follows the next state so the buzzer drops with the exit edge.
    tone_en    = enter_ring || ((state == ST_RING) && !leave_ring);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      ring_cnt  <= 8'h00;
      sec_q     <= 8'h00;
      match_a_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_h     <= 8'h00;
      snz_m     <= 8'h00;
      match_s_q <= 1'b0;
`endif
    end else begin
      sec_q     <= bus.second_bcd;
      match_a_q <= match_a;
`ifdef ALARM_SNOOZE_EN
      match_s_q <= match_s;
`endif
      if (!bus.alarm_en) begin
        state    <= ST_IDLE;
        ring_cnt <= 8'h00;
      end else begin
        case (state)
          ST_IDLE: begin
            if (trig_a) begin
              state    <= ST_RING;
              ring_cnt <= 8'h00;
            end
          end
          ST_RING: begin
            if (stop_req) begin
              state <= ST_IDLE;
            end
`ifdef ALARM_SNOOZE_EN
            else if (snooze_req) begin
              state          <= ST_SNOOZE;
              {snz_h, snz_m} <= bcd_add_hm(bus.hour_bcd, bus.minute_bcd, SNOOZE_MIN);
            end
`endif
            else if (tick) begin
              if (ring_cnt == RING_LAST) begin
                state    <= ST_IDLE;
                ring_cnt <= 8'h00;
              end else begin
                ring_cnt <= ring_cnt + 8'd1;
              end
            end
          end
`ifdef ALARM_SNOOZE_EN
          ST_SNOOZE: begin
            if (bus.stop_key) begin
              state <= ST_IDLE;
            end else if (trig_s) begin
              state    <= ST_RING;
              ring_cnt <= 8'h00;
            end
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  alarm_tone_gen #(
    .CLK_FREQ (CLK_FREQ),
    .TONE_HZ  (TONE_HZ)
  ) u_tone (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .en     (tone_en),
    .start  (enter_ring),
    .buzzer (buzzer)
  );

  assign bus.buzzer  = buzzer;
  assign bus.ringing = (state == ST_RING);
`ifdef ALARM_SNOOZE_EN
  assign bus.snoozed = (state == ST_SNOOZE);
`else
  assign bus.snoozed = 1'b0;
`endif
  assign bus.state   = state;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl at CLK_FREQ=1000, TONE_HZ=100 (5-cycle tone
// toggle, 500-cycle pattern halves), RING_SECS=60, SNOOZE_MIN=5.
module tb_alarm_ctrl;
  import alarm_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  alarm_ctrl_if bus();

  alarm_ctrl #(
    .CLK_FREQ   (1000),
    .TONE_HZ    (100),
    .RING_SECS  (60),
    .SNOOZE_MIN (5)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Inputs change and outputs are sampled only at falling edges.
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.hour_bcd   = h;
    bus.minute_bcd = m;
    bus.second_bcd = s;
  endtask

  // Arms alarm ah:am, walks time ph:pm:59 -> ah:am:00; returns one cycle later.
  task automatic start_ring(input logic [7:0] ph, input logic [7:0] pm,
                            input logic [7:0] ah, input logic [7:0] am);
    step();
    bus.alarm_hour   = ah;
    bus.alarm_minute = am;
    set_time(ph, pm, 8'h59);
    step(2);
    set_time(ah, am, 8'h00);
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.alarm_en     = 1'b1;
    bus.stop_key     = 1'b0;
    bus.snooze_key   = 1'b0;
    bus.alarm_hour   = 8'h07;
    bus.alarm_minute = 8'h30;
    set_time(8'h07, 8'h29, 8'h59);
    step(2);
    tests++; if (bus.ringing !== 1'b0) begin fails++; $display("FAIL reset_ringing: got %b want 0", bus.ringing); end
    tests++; if (bus.buzzer !== 1'b0) begin fails++; $display("FAIL reset_buzzer: got %b want 0", bus.buzzer); end
    tests++; if (bus.snoozed !== 1'b0) begin fails++; $display("FAIL reset_snoozed: got %b want 0", bus.snoozed); end
    tests++; if (bus.state !== ST_IDLE) begin fails++; $display("FAIL reset_state: got %0d want %0d", bus.state, ST_IDLE); end
    rst = 1'b0;
    step(3);
    tests++; if (bus.ringing !== 1'b0) begin fails++; $display("FAIL pre_alarm_idle: got %b want 0", bus.ringing); end
  endtask

  task automatic test_trigger_pattern();
    int  bad_buz;
    int  bad_ring;
    logic exp_buz;
    bad_buz  = 0;
    bad_ring = 0;
    set_time(8'h07, 8'h30, 8'h00);
    step();
    tests++; if (bus.ringing !== 1'b1) begin fails++; $display("FAIL trig_ringing: got %b want 1", bus.ringing); end
    tests++; if (bus.state !== ST_RING) begin fails++; $display("FAIL trig_state: got %0d want %0d", bus.state, ST_RING); end
    tests++; if (bus.buzzer !== 1'b1) begin fails++; $display("FAIL trig_buzzer_first: got %b want 1", bus.buzzer); end
    for (int k = 0; k < 1000; k++) begin
      exp_buz = (k < 500) ? (((k / 5) % 2) == 0) : 1'b0;
      if (bus.buzzer !== exp_buz) bad_buz++;
      if (bus.ringing !== 1'b1) bad_ring++;
      step();
    end
    tests++; if (bad_buz != 0) begin fails++; $display("FAIL buzzer_pattern: %0d wrong cycles, want 0", bad_buz); end
    tests++; if (bad_ring != 0) begin fails++; $display("FAIL ringing_hold: %0d wrong cycles, want 0", bad_ring); end
    tests++; if (bus.buzzer !== 1'b1) begin fails++; $display("FAIL pattern_second_on: got %b want 1", bus.buzzer); end
  endtask

  task automatic test_ring_timeout();
    for (int i = 1; i < 60; i++) begin
      set_time(8'h07, 8'h30, to_bcd(i));
      step(2);
    end
    tests++; if (bus.ringing !== 1'b1) begin fails++; $display("FAIL timeout_59_ticks: got %b want 1", bus.ringing); end
    set_time(8'h07, 8'h31, 8'h00);
    step();
    tests++; if (bus.ringing !== 1'b0) begin fails++; $display("FAIL timeout_60_ringing: got %b want 0", bus.ringing); end
    tests++; if (bus.buzzer !== 1'b0) begin fails++; $display("FAIL timeout_60_buzzer: got %b want 0", bus.buzzer); end
    tests++; if (bus.state !== ST_IDLE) begin fails++; $display("FAIL timeout_state: got %0d want %0d", bus.state, ST_IDLE); end
  endtask

  task automatic test_stop();
    start_ring(8'h09, 8'h14, 8'h09, 8'h15);
    tests++; if (bus.ringing !== 1'b1) begin fails++; $display("FAIL stop_ring_start: got %b want 1", bus.ringing); end
    step(3);
    bus.stop_key = 1'b1;
    step();
    bus.stop_key = 1'b0;
    tests++; if (bus.ringing !== 1'b0) begin fails++; $display("FAIL stop_ringing: got %b want 0", bus.ringing); end
    tests++; if (bus.buzzer !== 1'b0) begin fails++; $display("FAIL stop_buzzer: got %b want 0", bus.buzzer); end
    step(5);
    tests++; if (bus.ringing !== 1'b0) begin fails++; $display("FAIL stop_no_retrigger: got %b want 0", bus.ringing); end
  endtask

  task automatic test_both_keys();
    start_ring(8'h09, 8'h59, 8'h10, 8'h00);
    tests++; if (bus.ringing !== 1'b1) begin fails++; $display("FAIL both_ring_start: got %b want 1", bus.ringing); end
    bus.stop_key   = 1'b1;
    bus.snooze_key = 1'b1;
    step();
    bus.stop_key   = 1'b0;
    bus.snooze_key = 1'b0;
    tests++; if (bus.state !== ST_IDLE) begin fails++; $display("FAIL both_state: got %0d want %0d", bus.state, ST_IDLE); end
    tests++; if (bus.snoozed !== 1'b0) begin fails++; $display("FAIL both_snoozed: got %b want 0", bus.snoozed); end
  endtask

`ifdef ALARM_SNOOZE_EN
  task automatic test_snooze();
    start_ring(8'h23, 8'h57, 8'h23, 8'h58);
    tests++; if (bus.ringing !== 1'b1) begin fails++; $display("FAIL snz_ring_start: got %b want 1", bus.ringing); end
    step(2);
    bus.snooze_key = 1'b1;
    step();
    bus.snooze_key = 1'b0;
    tests++; if (bus.snoozed !== 1'b1) begin fails++; $display("FAIL snz_snoozed: got %b want 1", bus.snoozed); end
    tests++; if (bus.ringing !== 1'b0) begin fails++; $display("FAIL snz_ringing: got %b want 0", bus.ringing); end
    tests++; if (bus.buzzer !== 1'b0) begin fails++; $display("FAIL snz_buzzer: got %b want 0", bus.buzzer); end
    bus.snooze_key = 1'b1;
    step();
    bus.snooze_key = 1'b0;
    step();
    tests++; if (bus.state !== ST_SNOOZE) begin fails++; $display("FAIL snz_key_ignored: got %0d want %0d", bus.state, ST_SNOOZE); end
    set_time(8'h00, 8'h02, 8'h59);
    step(2);
    tests++; if (bus.ringing !== 1'b0) begin fails++; $display("FAIL snz_early: got %b want 0", bus.ringing); end
    set_time(8'h00, 8'h03, 8'h00);
    step();
    tests++; if (bus.ringing !== 1'b1) begin fails++; $display("FAIL snz_rering: got %b want 1", bus.ringing); end
    tests++; if (bus.snoozed !== 1'b0) begin fails++; $display("FAIL snz_rering_snoozed: got %b want 0", bus.snoozed); end
    step(2);
    bus.stop_key = 1'b1;
    step();
    bus.stop_key = 1'b0;
    tests++; if (bus.state !== ST_IDLE) begin fails++; $display("FAIL snz_final_stop: got %0d want %0d", bus.state, ST_IDLE); end
  endtask
`else
  task automatic test_snooze();
    start_ring(8'h23, 8'h57, 8'h23, 8'h58);
    tests++; if (bus.ringing !== 1'b1) begin fails++; $display("FAIL snz_ring_start: got %b want 1", bus.ringing); end
    bus.snooze_key = 1'b1;
    step();
    bus.snooze_key = 1'b0;
    tests++; if (bus.state !== ST_IDLE) begin fails++; $display("FAIL snz_as_stop_state: got %0d want %0d", bus.state, ST_IDLE); end
    tests++; if (bus.buzzer !== 1'b0) begin fails++; $display("FAIL snz_as_stop_buzzer: got %b want 0", bus.buzzer); end
    tests++; if (bus.snoozed !== 1'b0) begin fails++; $display("FAIL snz_tied_low: got %b want 0", bus.snoozed); end
    step(5);
    tests++; if (bus.ringing !== 1'b0) begin fails++; $display("FAIL snz_no_retrigger: got %b want 0", bus.ringing); end
  endtask
`endif

  task automatic test_snooze_idle();
    bus.snooze_key = 1'b1;
    step();
    bus.snooze_key = 1'b0;
    step();
    tests++; if (bus.state !== ST_IDLE) begin fails++; $display("FAIL snz_idle_state: got %0d want %0d", bus.state, ST_IDLE); end
    tests++; if (bus.snoozed !== 1'b0) begin fails++; $display("FAIL snz_idle_snoozed: got %b want 0", bus.snoozed); end
  endtask

  task automatic test_en_priority();
    start_ring(8'h07, 8'h59, 8'h08, 8'h00);
    tests++; if (bus.ringing !== 1'b1) begin fails++; $display("FAIL en_ring_start: got %b want 1", bus.ringing); end
    bus.alarm_en   = 1'b0;
    bus.snooze_key = 1'b1;
    step();
    bus.snooze_key = 1'b0;
    tests++; if (bus.state !== ST_IDLE) begin fails++; $display("FAIL en_low_state: got %0d want %0d", bus.state, ST_IDLE); end
    tests++; if (bus.buzzer !== 1'b0) begin fails++; $display("FAIL en_low_buzzer: got %b want 0", bus.buzzer); end
    tests++; if (bus.snoozed !== 1'b0) begin fails++; $display("FAIL en_low_snoozed: got %b want 0", bus.snoozed); end
    set_time(8'h08, 8'h00, 8'h01);
    bus.alarm_en = 1'b1;
    step(2);
    tests++; if (bus.state !== ST_IDLE) begin fails++; $display("FAIL en_rearm_idle: got %0d want %0d", bus.state, ST_IDLE); end
  endtask

  task automatic test_retrigger_ignored();
    start_ring(8'h07, 8'h32, 8'h07, 8'h33);
    tests++; if (bus.ringing !== 1'b1) begin fails++; $display("FAIL retrig_start: got %b want 1", bus.ringing); end
    for (int i = 1; i < 59; i++) begin
      set_time(8'h07, 8'h33, to_bcd(i));
      step(2);
    end
    set_time(8'h07, 8'h33, 8'h00);
    step(2);
    tests++; if (bus.ringing !== 1'b1) begin fails++; $display("FAIL retrig_tick59: got %b want 1", bus.ringing); end
    set_time(8'h07, 8'h33, 8'h01);
    step();
    tests++; if (bus.ringing !== 1'b0) begin fails++; $display("FAIL retrig_no_restart: got %b want 0", bus.ringing); end
  endtask

  task automatic test_invalid_bcd();
    step();
    bus.alarm_hour   = 8'h7A;
    bus.alarm_minute = 8'h00;
    set_time(8'h7A, 8'h00, 8'h59);
    step(2);
    set_time(8'h7A, 8'h00, 8'h00);
    step(3);
    tests++; if (bus.ringing !== 1'b0) begin fails++; $display("FAIL invalid_hour: got %b want 0", bus.ringing); end
    bus.alarm_hour   = 8'h12;
    bus.alarm_minute = 8'h6A;
    set_time(8'h12, 8'h6A, 8'h59);
    step(2);
    set_time(8'h12, 8'h6A, 8'h00);
    step(3);
    tests++; if (bus.state !== ST_IDLE) begin fails++; $display("FAIL invalid_minute: got %0d want %0d", bus.state, ST_IDLE); end
  endtask

  task automatic test_reset_mid_ring();
    start_ring(8'h07, 8'h29, 8'h07, 8'h30);
    tests++; if (bus.ringing !== 1'b1) begin fails++; $display("FAIL rstmid_start: got %b want 1", bus.ringing); end
    step(2);
    tests++; if (bus.buzzer !== 1'b1) begin fails++; $display("FAIL rstmid_buzzer_on: got %b want 1", bus.buzzer); end
    #2 rst = 1'b1;
    #1;
    tests++; if (bus.buzzer !== 1'b0) begin fails++; $display("FAIL rstmid_async_buzzer: got %b want 0", bus.buzzer); end
    tests++; if (bus.ringing !== 1'b0) begin fails++; $display("FAIL rstmid_async_ringing: got %b want 0", bus.ringing); end
    step(2);
    rst = 1'b0;
    step();
    tests++; if (bus.ringing !== 1'b1) begin fails++; $display("FAIL rstmid_retrigger: got %b want 1", bus.ringing); end
    bus.stop_key = 1'b1;
    step();
    bus.stop_key = 1'b0;
    step(5);
    tests++; if (bus.ringing !== 1'b0) begin fails++; $display("FAIL rstmid_single: got %b want 0", bus.ringing); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_trigger_pattern();
    test_ring_timeout();
    test_stop();
    test_both_keys();
    test_snooze();
    test_snooze_idle();
    test_en_priority();
    test_retrigger_ignored();
    test_invalid_bcd();
    test_reset_mid_ring();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 12000000: sys_clk frequency in Hz.
REQ-002 Parameter TONE_HZ, default 2000: buzzer square-wave frequency in Hz.
REQ-003 Parameter RING_SECS, default 60: maximum ring duration in seconds, range 1..255.
REQ-004 Parameter SNOOZE_MIN, default 5: snooze interval in minutes, range 1..59.
REQ-005 sys_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 sys_rst  in  1  reset, asynchronous assert, active-high.
REQ-007 hour_bcd  in  8  current hour, packed BCD, 00..23.
REQ-008 minute_bcd  in  8  current minute, packed BCD, 00..59.
REQ-009 second_bcd  in  8  current second, packed BCD, 00..59.
REQ-010 alarm_hour  in  8  alarm hour, packed BCD.
REQ-011 alarm_minute  in  8  alarm minute, packed BCD.
REQ-012 alarm_en  in  1  level; alarm armed while high.
REQ-013 stop_key  in  1  single-cycle pulse; silences the alarm.
REQ-014 snooze_key  in  1  single-cycle pulse; postpones the alarm.
REQ-015 buzzer  out  1  buzzer drive, registered.
REQ-016 ringing  out  1  high in state RING.
REQ-017 snoozed  out  1  high in state SNOOZE.

Function
REQ-018 FSM states: IDLE, RING, SNOOZE; encoding is implementation-defined.
REQ-019 match = alarm_en & hour_bcd==tgt_h & minute_bcd==tgt_m & second_bcd==8'h00; tgt = alarm_hour/alarm_minute in IDLE, snooze target in SNOOZE.
REQ-020 Trigger = rising edge of match against its registered copy; exactly one trigger per matching minute.
REQ-021 IDLE->RING on trigger, 1-cycle latency; ring second counter cleared.
REQ-022 Second tick = second_bcd differs from its registered copy; RING counts ticks, RING->IDLE when count reaches RING_SECS.
REQ-023 RING: buzzer toggles every CLK_FREQ/(2*TONE_HZ) cycles during the "on" half of a 1 Hz pattern (half-period CLK_FREQ/2 cycles, starting "on" at RING entry); buzzer is 0 in the "off" half.
REQ-024 Buzzer is 0 in IDLE and SNOOZE, and is 0 on the cycle after any exit from RING.
REQ-025 stop_key in RING or SNOOZE -> IDLE next cycle.
REQ-026 snooze_key in RING -> SNOOZE; snooze target = (current hour:minute) + SNOOZE_MIN in BCD; minute wraps 59->00 with hour carry; hour wraps 23->00.
REQ-027 SNOOZE->RING on trigger against the snooze target; ring counter and pattern restart.
REQ-028 stop_key and snooze_key in the same cycle: stop wins.
REQ-029 snooze_key in IDLE or SNOOZE is ignored.
REQ-030 alarm_en low forces IDLE from any state on the next cycle; this has priority over all keys.
REQ-031 A trigger during RING is ignored; the ring counter is not restarted.
REQ-032 Invalid BCD inputs never match and never hang the FSM.

Reset
REQ-033 sys_rst high asynchronously forces: state IDLE, buzzer/ringing/snoozed 0, all counters 0, match/second copies 0, snooze target 00:00.
REQ-034 After deassertion, a trigger requires a fresh rising edge of match; a match already present at release does fire (copy resets to 0).

Configuration
REQ-035 Macro ALARM_SNOOZE_EN defined: SNOOZE state, snooze target and snooze_key behave per REQ-026..REQ-029.
REQ-036 ALARM_SNOOZE_EN undefined: SNOOZE state and target logic are absent; snooze_key acts as stop_key; snoozed is tied 0.

Structure
REQ-037 Shared package holds the FSM state typedef, the BCD add-with-wrap minute/hour helper, and the default tone/ring constants.
REQ-038 One sub-module, alarm_tone_gen (1 Hz pattern gating plus tone divider, enable input, buzzer output), is instantiated once.

Verification
REQ-039 CLK_FREQ=1000, TONE_HZ=100; alarm 07:30, en=1, time steps 07:29:59->07:30:00 -> ringing=1 one cycle later; buzzer toggles every 5 cycles for 500 cycles, then 0 for 500 cycles.
REQ-040 Ringing, 60 second ticks -> IDLE after the 60th tick, buzzer 0.
REQ-041 Alarm 23:58, snooze_key while ringing -> snoozed=1, target 00:03; time 00:03:00 -> ring again.
REQ-042 stop_key and snooze_key together in RING -> IDLE, snoozed stays 0.
REQ-043 sys_rst pulsed mid-ring -> buzzer and ringing 0 in the same cycle without a clock edge; time held at 07:30:00 after release -> single re-trigger.
REQ-044 Build without ALARM_SNOOZE_EN: snooze_key in RING -> IDLE, snoozed constantly 0.
